hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Consumer-side controller for the ID/EX pipeline register: watches the IDEX outputs, the decode-stage operands and the downstream stages.
//  Drives PC/IFID write enables, the IFID flush, the IDEX bubble and EX-stage forwarding selects.
//  Sequences HALT through a pipeline-drain FSM; optional stall/flush performance counters.
// PARAMETERS
//  DRAIN_CYCLES  3   cycles between HALT accepted in EX and HALT_OUT (EX->MEM->WB retire)
//  CNT_W         16  width of performance counters (saturating)
// PORTS
//  CLK            in   1   clock, rising edge
//  RSTn           in   1   async active-low reset
//  RF_RA1_ID      in   5   rs1 of instruction in ID
//  RF_RA2_ID      in   5   rs2 of instruction in ID
//  USE_RS1_ID     in   1   ID instruction reads rs1
//  USE_RS2_ID     in   1   ID instruction reads rs2
//  RF_RA1_IDEX    in   5   rs1 latched in ID/EX
//  RF_RA2_IDEX    in   5   rs2 latched in ID/EX
//  WA_IDEX        in   5   dest reg in ID/EX
//  RF_WE_IDEX     in   1   ID/EX writes RF
//  isLoad_IDEX    in   1   ID/EX is a load
//  HALT_IDEX      in   1   halt instruction in EX
//  BR_TAKEN_EX    in   1   EX resolved taken branch/jump (redirect PC)
//  WA_EXMEM       in   5   dest reg in EX/MEM
//  RF_WE_EXMEM    in   1   EX/MEM writes RF
//  WA_MEMWB       in   5   dest reg in MEM/WB
//  RF_WE_MEMWB    in   1   MEM/WB writes RF
//  PC_WE          out  1   PC register update enable
//  IFID_WE        out  1   IF/ID register load enable
//  IFID_FLUSH     out  1   IF/ID contents replaced by NOP
//  IDEX_BUBBLE    out  1   ID/EX loads all-zero controls (NOP)
//  FWD_A          out  2   EX operand A select: 00 RF, 01 MEM/WB, 10 EX/MEM
//  FWD_B          out  2   EX operand B select, same encoding
//  HALT_OUT       out  1   pipeline drained after HALT; sticky
//  STALL_CNT      out  CNT_W  load-use stall cycles (PERF only)
//  FLUSH_CNT      out  CNT_W  branch flush events (PERF only)
// BEHAVIOUR
//  Reset (RSTn=0, async): state=RUN, drain counter=0, HALT_OUT=0, counters=0.
//   Combinational outputs settle to PC_WE=1, IFID_WE=1, FLUSH=0, BUBBLE=0.
//  Forwarding (comb., all states): FWD_A=10 if RF_WE_EXMEM & WA_EXMEM!=0 & WA_EXMEM==RF_RA1_IDEX;
//   else 01 if RF_WE_MEMWB & WA_MEMWB!=0 & WA_MEMWB==RF_RA1_IDEX; else 00. EX/MEM wins on a double match.
//   FWD_B identical on RF_RA2_IDEX.
//  Load-use (comb.): LU = isLoad_IDEX & RF_WE_IDEX & WA_IDEX!=0 & ((USE_RS1_ID & RF_RA1_ID==WA_IDEX) | (USE_RS2_ID & RF_RA2_ID==WA_IDEX)).
//  FSM states RUN, DRAIN, HALTED; control priority in RUN: HALT > BR_TAKEN > LU > normal.
//   RUN, HALT_IDEX=1: PC_WE=0, IFID_WE=0, IDEX_BUBBLE=1; next DRAIN, cnt=DRAIN_CYCLES-1.
//   RUN, BR_TAKEN_EX=1: PC_WE=1, IFID_FLUSH=1, IDEX_BUBBLE=1; LU ignored (wrong path). 1-cycle penalty x2 slots.
//   RUN, LU=1: PC_WE=0, IFID_WE=0, IDEX_BUBBLE=1 for exactly one cycle; the next cycle re-evaluates with the bubble in EX.
//   DRAIN: PC_WE=0, IFID_WE=0, IDEX_BUBBLE=1; cnt decrements; cnt==0 -> HALTED.
//   HALTED: same freeze; HALT_OUT=1 (registered, asserts DRAIN_CYCLES cycles after the HALT cycle); exit only by reset.
//  Reset mid-DRAIN: immediate return to RUN, HALT_OUT=0.
//  DRAIN_CYCLES=1: RUN->DRAIN->HALTED with HALT_OUT one cycle after the HALT cycle (DRAIN lasts 1 cycle).
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: STALL_CNT +1 each RUN cycle with LU & !BR_TAKEN_EX & !HALT_IDEX;
//   FLUSH_CNT +1 each RUN cycle with BR_TAKEN_EX & !HALT_IDEX; both saturate at all-ones, frozen in DRAIN/HALTED.
//  Not defined: no counter flops; STALL_CNT and FLUSH_CNT tied to 0.
// TESTING
//  T1 reset: RSTn=0 mid-run -> PC_WE=1, IFID_WE=1, FWD=00, HALT_OUT=0, counters 0, async (no clock edge needed).
//  T2 lw x5 then add x6,x5,x1 (isLoad_IDEX=1, WA_IDEX=5, RF_RA1_ID=5) -> 1 cycle PC_WE=0, BUBBLE=1; then FWD_A=01; STALL_CNT=1.
//  T3 WA_EXMEM=WA_MEMWB=7, both WE, RF_RA2_IDEX=7 -> FWD_B=10; WA=0 with WE=1 -> FWD=00.
//  T4 BR_TAKEN_EX=1 with LU=1 same cycle -> PC_WE=1, IFID_FLUSH=1, BUBBLE=1; FLUSH_CNT=1, STALL_CNT unchanged.
//  T5 HALT_IDEX=1 at cycle n -> freeze from n, HALT_OUT=1 at n+3 (default), stays 1 despite further stimulus until RSTn=0.

Source files
------------

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline-side bundle for the hazard control unit.
// The pipeline datapath holds the master modport. It drives the decode, ID/EX
// and downstream-stage observations, and it receives the enables, the
// squash/bubble controls and the forwarding selects.
// The hazard unit holds the slave modport.
interface hazard_ctrl_unit_if #(
  parameter int CNT_W = 16
);

  // Decode-stage operand usage
  logic [4:0]       RF_RA1_ID;
  logic [4:0]       RF_RA2_ID;
  logic             USE_RS1_ID;
  logic             USE_RS2_ID;

  // Instruction currently held in ID/EX (executing)
  logic [4:0]       RF_RA1_IDEX;
  logic [4:0]       RF_RA2_IDEX;
  logic [4:0]       WA_IDEX;
  logic             RF_WE_IDEX;
  logic             isLoad_IDEX;
  logic             HALT_IDEX;
  logic             BR_TAKEN_EX;

  // Downstream producers
  logic [4:0]       WA_EXMEM;
  logic             RF_WE_EXMEM;
  logic [4:0]       WA_MEMWB;
  logic             RF_WE_MEMWB;

  // Controls back to the pipeline
  logic             PC_WE;
  logic             IFID_WE;
  logic             IFID_FLUSH;
  logic             IDEX_BUBBLE;
  logic [1:0]       FWD_A;
  logic [1:0]       FWD_B;
  logic             HALT_OUT;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  modport master (
    output RF_RA1_ID, RF_RA2_ID, USE_RS1_ID, USE_RS2_ID,
    output RF_RA1_IDEX, RF_RA2_IDEX, WA_IDEX, RF_WE_IDEX, isLoad_IDEX,
    output HALT_IDEX, BR_TAKEN_EX,
    output WA_EXMEM, RF_WE_EXMEM, WA_MEMWB, RF_WE_MEMWB,
    input  PC_WE, IFID_WE, IFID_FLUSH, IDEX_BUBBLE,
    input  FWD_A, FWD_B, HALT_OUT, STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  RF_RA1_ID, RF_RA2_ID, USE_RS1_ID, USE_RS2_ID,
    input  RF_RA1_IDEX, RF_RA2_IDEX, WA_IDEX, RF_WE_IDEX, isLoad_IDEX,
    input  HALT_IDEX, BR_TAKEN_EX,
    input  WA_EXMEM, RF_WE_EXMEM, WA_MEMWB, RF_WE_MEMWB,
    output PC_WE, IFID_WE, IFID_FLUSH, IDEX_BUBBLE,
    output FWD_A, FWD_B, HALT_OUT, STALL_CNT, FLUSH_CNT
  );

endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: consumer-side hazard controller for the ID/EX register.
//  - EX-stage forwarding selects. EX/MEM has priority over MEM/WB.
//    x0 is never forwarded.
//  - Load-use detection, which stalls PC/IFID for one cycle and injects a bubble.
//  - Taken-branch squash, which flushes IF/ID and bubbles ID/EX.
//  - A HALT drain FSM (RUN -> DRAIN -> HALTED). HALT_OUT rises in the last
//    drain cycle, DRAIN_CYCLES cycles after HALT was seen in EX. It then
//    stays high until reset.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the saturating
// STALL_CNT / FLUSH_CNT performance counters. When the macro is undefined,
// both outputs are tied to zero and no counter flops exist.
module hazard_ctrl_unit #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input logic              CLK,
  input logic              RSTn,
  hazard_ctrl_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // The drain counter only ever holds DRAIN_CYCLES-1 down to 0.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_t        state;
  state_t        state_next;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_next;
  logic          halt_out;
  logic          halt_out_next;

  logic          ex_hit_a;
  logic          mem_hit_a;
  logic          ex_hit_b;
  logic          mem_hit_b;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;

  logic          lu_rs1;
  logic          lu_rs2;
  logic          lu;

  logic          pc_we;
  logic          ifid_we;
  logic          ifid_flush;
  logic          idex_bubble;

  // Producer matches for the two EX operands. A write to x0 never counts.
  always_comb begin
    ex_hit_a  = bus.RF_WE_EXMEM && (bus.WA_EXMEM != 5'd0) &&
                (bus.WA_EXMEM == bus.RF_RA1_IDEX);
    mem_hit_a = bus.RF_WE_MEMWB && (bus.WA_MEMWB != 5'd0) &&
                (bus.WA_MEMWB == bus.RF_RA1_IDEX);
    ex_hit_b  = bus.RF_WE_EXMEM && (bus.WA_EXMEM != 5'd0) &&
                (bus.WA_EXMEM == bus.RF_RA2_IDEX);
    mem_hit_b = bus.RF_WE_MEMWB && (bus.WA_MEMWB != 5'd0) &&
                (bus.WA_MEMWB == bus.RF_RA2_IDEX);
  end

  // Forwarding selects. The younger EX/MEM result wins over MEM/WB.
  // The selects stay active in every FSM state.
  always_comb begin
    fwd_a = 2'b00;
    if (ex_hit_a) begin
      fwd_a = 2'b10;
    end else if (mem_hit_a) begin
      fwd_a = 2'b01;
    end

    fwd_b = 2'b00;
    if (ex_hit_b) begin
      fwd_b = 2'b10;
    end else if (mem_hit_b) begin
      fwd_b = 2'b01;
    end
  end

  // Load-use hazard: a load in EX targets a register that the ID instruction
  // actually reads.
  always_comb begin
    lu_rs1 = bus.USE_RS1_ID && (bus.RF_RA1_ID == bus.WA_IDEX);
    lu_rs2 = bus.USE_RS2_ID && (bus.RF_RA2_ID == bus.WA_IDEX);
    lu     = bus.isLoad_IDEX && bus.RF_WE_IDEX && (bus.WA_IDEX != 5'd0) &&
             (lu_rs1 || lu_rs2);
  end

  // State, drain counter and the sticky HALT_OUT flag.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= RUN;
      cnt      <= '0;
      halt_out <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      halt_out <= halt_out_next;
    end
  end

  // Next state and pipeline controls. In RUN the priority is
  // HALT > taken branch > load-use.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;

    unique case (state)
      RUN: begin
        if (bus.HALT_IDEX) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          state_next  = DRAIN;
          cnt_next    = DRAIN_LOAD;
        end else if (bus.BR_TAKEN_EX) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (lu) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      DRAIN: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        if (cnt == '0) begin
          state_next = HALTED;
        end else begin
          cnt_next = cnt - DW'(1);
        end
      end
      HALTED: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase

    halt_out_next = halt_out ||
                    ((state_next == DRAIN) && (cnt_next == '0));
  end

  assign bus.PC_WE       = pc_we;
  assign bus.IFID_WE     = ifid_we;
  assign bus.IFID_FLUSH  = ifid_flush;
  assign bus.IDEX_BUBBLE = idex_bubble;
  assign bus.FWD_A       = fwd_a;
  assign bus.FWD_B       = fwd_b;
  assign bus.HALT_OUT    = halt_out;

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_evt;
  logic             flush_evt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Count events only while running. A HALT in EX suppresses both counts.
  always_comb begin
    stall_evt = (state == RUN) && lu && !bus.BR_TAKEN_EX && !bus.HALT_IDEX;
    flush_evt = (state == RUN) && bus.BR_TAKEN_EX && !bus.HALT_IDEX;
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.STALL_CNT = stall_cnt;
  assign bus.FLUSH_CNT = flush_cnt;
`else
  assign bus.STALL_CNT = {CNT_W{1'b0}};
  assign bus.FLUSH_CNT = {CNT_W{1'b0}};
`endif

endmodule
